cmp_result_tracker: RTL and testbench
=====================================

// Module: cmp_result_tracker
// PURPOSE
//  Pipelined signed magnitude comparator stage with valid/ready handshake on both sides.
//  Accepts operand pairs (a, b) and emits a one-hot less/greater/equal verdict per pair.
//  Keeps saturating per-outcome event counters for downstream checkers and status readout.
//  Without the optional equal path, equal pairs produce no verdict and are only counted.
// PARAMETERS
//  WIDTH   32  operand width; operands are signed two's complement
//  CNT_W   16  width of each outcome counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      stage can accept a pair this cycle
//  a          in   WIDTH  operand A, signed
//  b          in   WIDTH  operand B, signed
//  out_valid  out  1      verdict valid
//  out_ready  in   1      downstream accepts verdict
//  lt         out  1      A < B
//  gt         out  1      B < A
//  eq         out  1      A == B (only with EQUAL_FLAG_EN, else constant 0)
//  clr        in   1      synchronous clear of all counters
//  cnt_lt     out  CNT_W  accepted A<B verdicts
//  cnt_gt     out  CNT_W  accepted B<A verdicts
//  cnt_eq     out  CNT_W  equal pairs seen (emitted or dropped)
// BEHAVIOUR
//  Reset (rst_n low, immediate): s1_valid=0, out_valid=0, lt=gt=eq=0, all counters 0, in_ready=1.
//  Stage 1 (S1): registers a,b on in_valid && in_ready. Stage 2 (S2): registers verdict.
//  in_ready = !s1_valid || s1_advance; s1_advance = s1_valid && (!out_valid || out_ready || s1_is_drop).
//  Latency: pair accepted at cycle N -> out_valid at N+2 with out_ready held high; throughput 1/clk.
//  Verdict decode is mutually exclusive: at most one of lt/gt/eq high whenever out_valid=1.
//  Comparison is signed: a=-1, b=1 gives lt.
//  out_valid with lt/gt/eq stable until out_valid && out_ready; back-pressure stalls S2 then S1,
//   then drops in_ready; no pair lost or duplicated.
//  Equal pair without EQUAL_FLAG_EN: on S1 advance it is consumed, cnt_eq increments, S2
//   unchanged (no beat emitted); a drop never waits on out_ready.
//  Counters: cnt_lt/cnt_gt increment on out_valid && out_ready for that verdict; cnt_eq
//   increments on emitted eq handshake or on drop. Saturate at all-ones, never wrap.
//  clr: counters become 0 next cycle; clr wins over a simultaneous increment. Pipeline unaffected.
//  Reset mid-operation discards S1/S2 contents; first post-reset accept behaves as from idle.
//  out_ready low with out_valid low has no effect; out_ready high with S1 empty clears out_valid.
// CONFIGURATION
//  EQUAL_FLAG_EN defined: equal pairs emit a beat with eq=1 through S2 like lt/gt;
//   cnt_eq counts eq handshakes.
//  EQUAL_FLAG_EN undefined: eq tied 0; equal pairs dropped at S1 as above; no eq storage in S2.
// STRUCTURE
//  Package cmp_pkg: typedef enum logic [1:0] {CMP_NONE, CMP_LT, CMP_GT, CMP_EQ} cmp_t;
//   function cmp_t cmp_decode(signed a, b) used by S1 and the bench model.
//  Sub-module sat_counter (CNT_W; inc, clr) instantiated three times.
//  Top holds S1/S2 registers and handshake logic.
// TESTING
//  1. Reset: rst_n low mid-stream with a=5,b=9 in S1 -> out_valid=0, counters 0, in_ready=1.
//  2. Stream (3,7),(7,3),(-2,1) out_ready=1 -> lt,gt,lt at N+2..N+4; cnt_lt=2, cnt_gt=1.
//  3. Back-pressure: out_ready=0 for 4 cycles during stream -> in_ready=0 after 2 accepts;
//     verdicts held stable; order preserved.
//  4. Equal pair (50,50): with EQUAL_FLAG_EN -> beat eq=1, cnt_eq=1; without -> no beat, cnt_eq=1.
//  5. Saturation: CNT_W=4, 20 lt pairs -> cnt_lt=15; clr with concurrent lt handshake -> 0.
//  6. Random signed pairs vs cmp_decode model, random out_ready -> no loss/dup, one-hot, counters match.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared verdict type and signed compare helper for cmp_result_tracker and its bench.
package cmp_pkg;

    localparam int unsigned CMP_MAX_W = 64;

    typedef enum logic [1:0] {CMP_NONE, CMP_LT, CMP_GT, CMP_EQ} cmp_t;

    // Operands are sign-extended to CMP_MAX_W by the caller.
    function automatic cmp_t cmp_decode(input logic signed [CMP_MAX_W-1:0] a,
                                        input logic signed [CMP_MAX_W-1:0] b);
        if (a < b)      return CMP_LT;
        else if (b < a) return CMP_GT;
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/cmp_result_tracker.sv
// Two-stage signed comparator with valid/ready handshake and saturating outcome counters.
// Optional EQUAL_FLAG_EN: equal pairs emit an eq beat instead of being dropped at S1.
module cmp_result_tracker
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    lt,
    output logic                    gt,
    output logic                    eq,
    input  logic                    clr,
    output logic [CNT_W-1:0]        cnt_lt,
    output logic [CNT_W-1:0]        cnt_gt,
    output logic [CNT_W-1:0]        cnt_eq
);

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    cmp_t                    s1_cmp;
    logic                    s1_is_drop;
    logic                    s1_advance;
    logic                    s2_load;
    logic                    inc_lt;
    logic                    inc_gt;
    logic                    inc_eq;

    always_comb begin
        s1_cmp = cmp_decode(CMP_MAX_W'(s1_a), CMP_MAX_W'(s1_b));
    end

`ifdef EQUAL_FLAG_EN
    assign s1_is_drop = 1'b0;
`else
    // Equal pairs never occupy S2, so they can retire even under back-pressure.
    assign s1_is_drop = s1_valid && (s1_cmp == CMP_EQ);
`endif

    assign s1_advance = s1_valid && (!out_valid || out_ready || s1_is_drop);
    assign in_ready   = !s1_valid || s1_advance;
    assign s2_load    = s1_advance && !s1_is_drop;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: verdict register, held until the downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            lt        <= (s1_cmp == CMP_LT);
            gt        <= (s1_cmp == CMP_GT);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end
    end

`ifdef EQUAL_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            eq <= 1'b0;
        else if (s2_load)
            eq <= (s1_cmp == CMP_EQ);
        else if (out_ready)
            eq <= 1'b0;
    end
    assign inc_eq = out_valid && out_ready && eq;
`else
    assign eq     = 1'b0;
    assign inc_eq = s1_advance && s1_is_drop;
`endif

    assign inc_lt = out_valid && out_ready && lt;
    assign inc_gt = out_valid && out_ready && gt;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_lt),
        .clr   (clr),
        .cnt   (cnt_lt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_gt),
        .clr   (clr),
        .cnt   (cnt_gt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_eq),
        .clr   (clr),
        .cnt   (cnt_eq)
    );

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Randomized self-checking bench for cmp_result_tracker against a queue-based verdict model.
module tb_cmp_result_tracker;

    localparam int W      = 32;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;
`ifdef EQUAL_FLAG_EN
    localparam bit EQ_EN = 1'b1;
`else
    localparam bit EQ_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] a = '0;
    logic signed [W-1:0] b = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                lt, gt, eq;
    logic                clr = 1'b0;
    logic [CW-1:0]       cnt_lt, cnt_gt, cnt_eq;

    cmp_result_tracker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq),
        .clr       (clr),
        .cnt_lt    (cnt_lt),
        .cnt_gt    (cnt_gt),
        .cnt_eq    (cnt_eq)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Expected verdict bits {lt,gt,eq} from plain signed arithmetic.
    function automatic logic [2:0] model_verdict(input int x, input int y);
        if (x < y)      return 3'b100;
        else if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNTMAX) ? v : v + 1;
    endfunction

    typedef struct {
        logic [2:0] v;
        int         c;
    } exp_t;

    exp_t       q[$];
    int         m_lt = 0, m_gt = 0, m_eq = 0;
    int         n_acc = 0, n_hs = 0;
    bit         hold_prev = 1'b0;
    logic [2:0] prev_flags = '0;
    bit         exact_lat = 1'b0;
    bit         rand_rdy = 1'b0;

    // Compare process: every falling edge, DUT outputs vs model
    initial forever begin
        exp_t       e;
        logic [2:0] v;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            m_lt = 0; m_gt = 0; m_eq = 0;
            hold_prev = 1'b0;
            continue;
        end
        chk("cnt_lt", cnt_lt, m_lt);
        chk("cnt_gt", cnt_gt, m_gt);
        if (EQ_EN) chk("cnt_eq", cnt_eq, m_eq);
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_flags", {lt, gt, eq}, prev_flags);
        end
        if (out_valid) chk("onehot", $countones({lt, gt, eq}), 1);
        if (out_valid && out_ready) begin
            n_hs++;
            chk("beat_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("verdict", {lt, gt, eq}, e.v);
                if (exact_lat) chk("latency", cyc - e.c, 2);
                else           chk("latency_min", (cyc - e.c) >= 2, 1);
                if (e.v == 3'b100) m_lt = sat_inc(m_lt);
                if (e.v == 3'b010) m_gt = sat_inc(m_gt);
                if (e.v == 3'b001) m_eq = sat_inc(m_eq);
            end
        end
        hold_prev  = out_valid && !out_ready;
        prev_flags = {lt, gt, eq};
        if (in_valid && in_ready) begin
            n_acc++;
            v = model_verdict(a, b);
            if (v == 3'b001 && !EQ_EN) m_eq = sat_inc(m_eq);
            else q.push_back('{v, cyc});
        end
        if (clr) begin
            m_lt = 0; m_gt = 0; m_eq = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        bit got = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drained", done, 1);
        repeat (3) @(negedge clk);
        chk("cnt_eq_drain", cnt_eq, m_eq);
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int hs0, acc0;
        bit seen;
        logic signed [W-1:0] x, y;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Ordered stream, exact two-cycle latency
        exact_lat = 1'b1;
        send(3, 7);
        send(7, 3);
        send(-2, 1);
        drain();
        chk("stream_cnt_lt", cnt_lt, 2);
        chk("stream_cnt_gt", cnt_gt, 1);

        // Reset with a pair sitting in S1
        in_valid = 1'b1; a = 5; b = 9;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt_lt", cnt_lt, 0);
        chk("rst_cnt_gt", cnt_gt, 0);
        chk("rst_flags", {lt, gt, eq}, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        send(-1, 1);
        drain();
        chk("post_rst_cnt_lt", cnt_lt, 1);
        exact_lat = 1'b0;

        // Back-pressure: S2 then S1 fill, then in_ready drops
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send(1, 2);
                send(9, 4);
                send(-5, -6);
                send(-7, 0);
            end
        join_none
        repeat (4) tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_accepts", n_acc - acc0, 2);
        out_ready = 1'b1;
        wait fork;
        drain();

        // Equal pair
        pulse_clr();
        exact_lat = 1'b1;
        hs0 = n_hs;
        send(50, 50);
        drain();
        chk("eq_cnt", cnt_eq, 1);
        chk("eq_beats", n_hs - hs0, EQ_EN ? 1 : 0);
        exact_lat = 1'b0;

        // Saturation and clear-beats-increment
        pulse_clr();
        for (int i = 0; i < 20; i++) send(W'(i), W'(i + 100));
        drain();
        chk("sat_cnt_lt", cnt_lt, 15);
        out_ready = 1'b0;
        send(-3, 3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("clr_beat_seen", seen, 1);
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", cnt_lt, 0);
        tick();
        drain();

        // Random signed pairs with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: begin x = W'($urandom); y = x; end
                1: begin x = W'(int'($urandom_range(0, 8)) - 4); y = W'(int'($urandom_range(0, 8)) - 4); end
                2: begin x = W'($urandom); y = W'($urandom); end
                default: begin
                    x = $urandom_range(0, 1) ? W'(32'h8000_0000) : W'(32'h7FFF_FFFF);
                    y = $urandom_range(0, 1) ? W'(32'h8000_0000) : W'(-1);
                end
            endcase
            send(x, y);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_rdy = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
